uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter core (8N1, uart_tx_en / uart_tx_data / uart_tx_busy interface) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin and packet-locked: a winner keeps the transmitter until it hands over a byte marked last.
- An optional header byte carrying the requester ID precedes each packet.
- Sits in impl_top between on-chip status/echo sources and the shared UART TX path.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration path: byte width, header
// nibble and the arbiter state encoding.
package uart_pkg;
  localparam int         BYTE_W          = 8;
  localparam logic [3:0] UART_HDR_NIBBLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEND,
    ST_WAIT_START,
    ST_WAIT_DONE
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req scanning upward from
// ptr+1 (wrapping), returned as one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  int cand;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one 8N1 UART transmitter between
// NUM_REQ byte streams, with an optional {F, id} header byte per packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter bit HDR_EN  = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      uart_tx_busy,
  output logic                      uart_tx_en,
  output logic [BYTE_W-1:0]         uart_tx_data,
  output logic                      arb_busy
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state, state_n;
  logic [IW-1:0]       rr_ptr, rr_ptr_n, win, win_n;
  logic                last_flag, last_n;
  logic [NUM_REQ-1:0]  grant_n, ready_n;
  logic                en_n;
  logic [BYTE_W-1:0]   data_n;
  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      rr_ptr       <= IW'(NUM_REQ - 1);
      win          <= '0;
      last_flag    <= 1'b0;
      grant        <= '0;
      req_ready    <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      arb_busy     <= 1'b0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      win          <= win_n;
      last_flag    <= last_n;
      grant        <= grant_n;
      req_ready    <= ready_n;
      uart_tx_en   <= en_n;
      uart_tx_data <= data_n;
      arb_busy     <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    win_n    = win;
    last_n   = last_flag;
    grant_n  = grant;
    ready_n  = '0;
    en_n     = 1'b0;
    data_n   = uart_tx_data;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_n  = pick_oh;
          rr_ptr_n = pick_idx;
          win_n    = pick_idx;
          state_n  = HDR_EN ? ST_HDR : ST_SEND;
        end
      end
      ST_HDR: begin
        // last_flag=0 makes WAIT_DONE continue into the data phase
        if (!uart_tx_busy) begin
          en_n    = 1'b1;
          data_n  = {UART_HDR_NIBBLE, 4'(win)};
          last_n  = 1'b0;
          state_n = ST_WAIT_START;
        end
      end
      ST_SEND: begin
        if (req_valid[win] && !uart_tx_busy) begin
          en_n         = 1'b1;
          data_n       = req_data[BYTE_W*win +: BYTE_W];
          ready_n[win] = 1'b1;
          last_n       = req_last[win];
          state_n      = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (uart_tx_busy) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_flag) begin
            grant_n = '0;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_SEND;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a UART busy model and a
// frame-level scoreboard with a round-robin winner model, checked every cycle.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant;
  logic [31:0] req_data = '0;
  logic        busy = 1'b0, uart_tx_en, arb_busy;
  logic [7:0]  uart_tx_data;
  // second instance without headers
  logic [3:0]  req_valid_b = '0, req_last_b = '0, req_ready_b, grant_b;
  logic [31:0] req_data_b = '0;
  logic        busy_b = 1'b0, uart_tx_en_b, arb_busy_b;
  logic [7:0]  uart_tx_data_b;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .uart_tx_busy(busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .arb_busy(arb_busy));

  uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(0)) u_dut_nohdr (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .grant(grant_b),
    .uart_tx_busy(busy_b), .uart_tx_en(uart_tx_en_b), .uart_tx_data(uart_tx_data_b),
    .arb_busy(arb_busy_b));

  int tests = 0, fails = 0;
  int busy_dly = 1, busy_len = 20;
  int strobe_cnt = 0, ready_cnt = 0;

  typedef struct { logic [7:0] data; bit hdr; int owner; } exp_t;
  exp_t exp_q[$];
  logic [7:0] q_d[4][$];
  bit         q_l[4][$];
  bit [3:0]   hold = '0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add_byte(input int id, input logic [7:0] d, input bit last);
    q_d[id].push_back(d);
    q_l[id].push_back(last);
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit hdr, input int owner);
    exp_t e;
    e.data = d; e.hdr = hdr; e.owner = owner;
    exp_q.push_back(e);
  endtask

  // Round-robin rule from the pointer: first valid after ptr, wrapping.
  function automatic int rr_next(input logic [3:0] v, input int p);
    for (int k = 1; k <= 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Requester driver: pop on the ready pulse, present the queue head.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && q_d[i].size() > 0) begin
          void'(q_d[i].pop_front());
          void'(q_l[i].pop_front());
        end
      for (int i = 0; i < 4; i++) begin
        req_valid[i]      = (q_d[i].size() > 0) && !hold[i];
        req_data[8*i +: 8] = (q_d[i].size() > 0) ? q_d[i][0] : 8'h00;
        req_last[i]       = (q_l[i].size() > 0) ? q_l[i][0] : 1'b0;
      end
    end
  end

  // UART core models: busy rises busy_dly edges after the strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_en) begin
        repeat (busy_dly) @(posedge clk);
        #1 busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy = 1'b0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_en_b) begin
        @(posedge clk); #1 busy_b = 1'b1;
        repeat (20) @(posedge clk);
        #1 busy_b = 1'b0;
      end
    end
  end

  // Per-cycle compare against the scoreboard and the winner model.
  int         m_ptr = 3;
  logic [3:0] prev_valid = '0, prev_grant = '0;
  bit         frame_open = 0, seen_busy = 0;
  initial begin
    exp_t e;
    int   w;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk(grant == 0 && req_ready == 0 && !uart_tx_en && uart_tx_data == 0 && !arb_busy,
            "reset_outputs", {grant, req_ready, 7'd0, uart_tx_en, uart_tx_data, 7'd0, arb_busy}, 32'h0);
        m_ptr = 3;
        prev_grant = '0;
      end else begin
        chk(arb_busy == (grant != 0), "arb_busy", 32'(arb_busy), 32'(grant != 0));
        chk($onehot0(grant), "grant_onehot", 32'(grant), 32'h0);
        if (req_ready != 0) begin
          ready_cnt++;
          chk((req_ready & ~grant) == 0 && $onehot(req_ready) && uart_tx_en,
              "ready_qual", 32'(req_ready), 32'(grant));
        end
        if (prev_grant == 0 && grant != 0) begin
          w = rr_next(prev_valid, m_ptr);
          chk(w >= 0 && grant == 4'(1 << w), "rr_winner", 32'(grant), (w >= 0) ? 32'(1 << w) : 32'h0);
          if (w >= 0) m_ptr = w;
        end
        if (uart_tx_en) begin
          strobe_cnt++;
          chk(exp_q.size() > 0, "strobe_expected", 32'(uart_tx_data), 32'h0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(uart_tx_data == e.data, "tx_data", 32'(uart_tx_data), 32'(e.data));
            chk(grant == 4'(1 << e.owner), "strobe_owner", 32'(grant), 32'(1 << e.owner));
            chk(req_ready == (e.hdr ? 4'b0 : 4'(1 << e.owner)), "ready_pulse",
                32'(req_ready), e.hdr ? 32'h0 : 32'(1 << e.owner));
          end
        end
        prev_grant = grant;
      end
      // a new frame may start only after the previous busy rose and fell
      if (uart_tx_en) begin
        chk(!frame_open, "strobe_while_frame_open", 32'(frame_open), 32'h0);
        frame_open = 1; seen_busy = 0;
      end else if (frame_open) begin
        if (busy) seen_busy = 1;
        else if (seen_busy) frame_open = 0;
      end
      prev_valid = req_valid;
    end
  end

  // Monitor for the header-less instance.
  int         b_strobes = 0, b_run = 0, b_max_run = 0;
  logic [7:0] b_data = '0;
  logic [3:0] b_ready = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_en_b) begin
        b_strobes++; b_run++; b_data = uart_tx_data_b;
        if (b_run > b_max_run) b_max_run = b_run;
      end else b_run = 0;
      if (req_ready_b != 0) b_ready = req_ready_b;
    end
  end

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || grant != 0 || busy) && n < max) begin
      @(negedge clk); n++;
    end
    chk(n < max, name, 32'(n), 32'(max));
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int sc, rc, n;
    repeat (4) @(negedge clk);
    chk(grant == 0 && uart_tx_data == 8'h00 && !arb_busy, "reset_state",
        {20'd0, grant, uart_tx_data}, 32'h0);
    resetn = 1'b1;

    // single requester, two-byte packet
    sc = strobe_cnt; rc = ready_cnt;
    add_byte(1, 8'hAB, 0); add_byte(1, 8'h5C, 1);
    expect_frame(8'hF1, 1, 1); expect_frame(8'hAB, 0, 1); expect_frame(8'h5C, 0, 1);
    wait_idle(2000, "t1_timeout");
    chk(strobe_cnt - sc == 3, "t1_strobes", 32'(strobe_cnt - sc), 32'd3);
    chk(ready_cnt - rc == 2, "t1_readies", 32'(ready_cnt - rc), 32'd2);
    chk(grant == 4'b0000, "t1_grant_released", 32'(grant), 32'h0);

    // simultaneous requesters 0 and 2, then 0 again against new 3
    do_reset();
    add_byte(0, 8'h11, 1); add_byte(2, 8'h22, 1);
    expect_frame(8'hF0, 1, 0); expect_frame(8'h11, 0, 0);
    expect_frame(8'hF2, 1, 2); expect_frame(8'h22, 0, 2);
    wait_idle(3000, "t2a_timeout");
    add_byte(0, 8'h12, 1); add_byte(3, 8'h33, 1);
    expect_frame(8'hF3, 1, 3); expect_frame(8'h33, 0, 3);
    expect_frame(8'hF0, 1, 0); expect_frame(8'h12, 0, 0);
    wait_idle(3000, "t2b_timeout");

    // packet lock while the owner stalls
    add_byte(1, 8'hA1, 0); add_byte(1, 8'hA2, 0); add_byte(1, 8'hA3, 1);
    expect_frame(8'hF1, 1, 1); expect_frame(8'hA1, 0, 1); expect_frame(8'hA2, 0, 1);
    expect_frame(8'hA3, 0, 1); expect_frame(8'hF0, 1, 0); expect_frame(8'hB0, 0, 0);
    n = 0;
    while (q_d[1].size() != 2 && n < 1000) begin @(negedge clk); n++; end
    chk(n < 1000, "t3_first_byte_timeout", 32'(n), 32'd1000);
    hold[1] = 1'b1;
    add_byte(0, 8'hB0, 1);
    sc = strobe_cnt;
    repeat (100) begin
      @(negedge clk);
      if (grant != 4'b0010) chk(0, "t3_lock_grant", 32'(grant), 32'h2);
    end
    chk(grant == 4'b0010, "t3_grant_held", 32'(grant), 32'h2);
    chk(strobe_cnt == sc, "t3_no_strobe", 32'(strobe_cnt - sc), 32'd0);
    hold[1] = 1'b0;
    wait_idle(4000, "t3_timeout");

    // slow baud: busy 3 cycles late, 5208 cycles per frame
    busy_dly = 3; busy_len = 5208;
    add_byte(2, 8'hC1, 0); add_byte(2, 8'hC2, 1);
    expect_frame(8'hF2, 1, 2); expect_frame(8'hC1, 0, 2); expect_frame(8'hC2, 0, 2);
    wait_idle(20000, "t4_timeout");
    busy_dly = 1;

    // reset in WAIT_DONE of byte 2
    busy_len = 200;
    sc = strobe_cnt;
    add_byte(3, 8'hD1, 0); add_byte(3, 8'hD2, 0); add_byte(3, 8'hD3, 1);
    expect_frame(8'hF3, 1, 3); expect_frame(8'hD1, 0, 3); expect_frame(8'hD2, 0, 3);
    n = 0;
    while (strobe_cnt - sc < 3 && n < 3000) begin @(negedge clk); n++; end
    chk(n < 3000, "t5_byte2_timeout", 32'(n), 32'd3000);
    repeat (30) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk(grant == 0 && req_ready == 0 && !uart_tx_en && !arb_busy && uart_tx_data == 8'h00,
           "t5_async_reset", {20'd0, grant, uart_tx_data}, 32'h0);
    exp_q.delete();
    add_byte(1, 8'hE1, 1);
    expect_frame(8'hF1, 1, 1); expect_frame(8'hE1, 0, 1);
    expect_frame(8'hF3, 1, 3); expect_frame(8'hD3, 0, 3);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_idle(4000, "t5_timeout");
    busy_len = 20;

    // header-less instance, one byte from requester 3
    req_data_b[31:24] = 8'hF0; req_last_b[3] = 1'b1; req_valid_b[3] = 1'b1;
    n = 0;
    while (req_ready_b == 0 && n < 200) begin @(negedge clk); n++; end
    chk(n < 200, "t6_ready_timeout", 32'(n), 32'd200);
    req_valid_b = '0; req_last_b = '0;
    n = 0;
    while ((grant_b != 0 || busy_b) && n < 500) begin @(negedge clk); n++; end
    chk(n < 500, "t6_idle_timeout", 32'(n), 32'd500);
    repeat (5) @(negedge clk);
    chk(b_strobes == 1, "t6_one_frame", 32'(b_strobes), 32'd1);
    chk(b_data == 8'hF0, "t6_data", 32'(b_data), 32'hF0);
    chk(b_max_run == 1, "t6_strobe_width", 32'(b_max_run), 32'd1);
    chk(b_ready == 4'b1000, "t6_ready_owner", 32'(b_ready), 32'h8);
    chk(!arb_busy_b && grant_b == 0, "t6_released", {27'd0, arb_busy_b, grant_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
